// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame controller and its timer.
package uart_frame_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_LEN,
      ST_PAYLOAD,
      ST_CSUM,
      ST_COMMIT,
      ST_RXRST
   } state_t;

   localparam logic [1:0] ERR_CSUM = 2'd0;
   localparam logic [1:0] ERR_LEN  = 2'd1;
   localparam logic [1:0] ERR_TO   = 2'd2;
   localparam logic [1:0] ERR_UART = 2'd3;

   localparam logic [7:0] SOF_DEFAULT = 8'hA5;

   // States in which the inter-byte timeout is armed.
   function automatic logic is_timed(input state_t s);
      return (s == ST_CMD) || (s == ST_LEN) || (s == ST_PAYLOAD) || (s == ST_CSUM);
   endfunction

endpackage

// File: rtl/uart_frame_timer.sv
// Inter-byte timeout: down-counter reloaded on clear, expires at terminal count zero.
module uart_frame_timer
   import uart_frame_pkg::*;
#(
   parameter int TO_W    = 16,
   parameter int TIMEOUT = 640
) (
   input  logic clkx16,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam logic [TO_W-1:0] LOAD_VAL = TO_W'(TIMEOUT - 1);

   logic [TO_W-1:0] cnt_q;
   logic [TO_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = LOAD_VAL;
      end else if (en) begin
         cnt_d = cnt_q - TO_W'(1);
      end
   end

   always_ff @(posedge clkx16) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Reaching zero while armed is TIMEOUT cycles after the last reload.
   assign expire = en && (cnt_q == '0);

endmodule

// File: rtl/uart_frame_ctrl.sv
// Frame parser between the UART byte receiver and the register file; replays a
// buffered payload as register writes only after the checksum matches.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  IDLE    | hunting for SOF, other bytes discarded
//  CMD     | waiting for the command byte
//  LEN     | waiting for the payload length byte
//  PAYLOAD | filling the payload buffer
//  CSUM    | waiting for the checksum byte
//  COMMIT  | one register write per cycle, frame_ok after the last
//  RXRST   | holding the receiver in reset for two cycles
module uart_frame_ctrl
   import uart_frame_pkg::*;
#(
   parameter int         MAX_LEN = 8,
   parameter int         AW      = 3,
   parameter int         TO_W    = 16,
   parameter int         TIMEOUT = 640,
   parameter logic [7:0] SOF     = SOF_DEFAULT
) (
   input  logic          clkx16,
   input  logic          reset,
   input  logic [7:0]    rx_data,
   input  logic          rx_load,
   input  logic          rx_error,
   output logic          uart_rst,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic [7:0]    wr_data,
   output logic [7:0]    wr_cmd,
   output logic          frame_ok,
   output logic          frame_err,
   output logic [1:0]    err_code,
   output logic          busy
);

   localparam int         LW        = $clog2(MAX_LEN + 1);
   localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

   state_t          state_q, state_d;
   logic [7:0]      cmd_q, cmd_d;
   logic [LW-1:0]   len_q, len_d;
   logic [AW-1:0]   idx_q, idx_d;
   logic [7:0]      sum_q, sum_d;
   logic [7:0]      pbuf_q [MAX_LEN];
   logic [7:0]      pbuf_d [MAX_LEN];
   logic            rst_cnt_q, rst_cnt_d;
   logic            rx_err_q, rx_err_d;
   logic            wr_en_q, wr_en_d;
   logic [AW-1:0]   wr_addr_q, wr_addr_d;
   logic [7:0]      wr_data_q, wr_data_d;
   logic [7:0]      wr_cmd_q, wr_cmd_d;
   logic            frame_ok_q, frame_ok_d;
   logic            frame_err_q, frame_err_d;
   logic [1:0]      err_code_q, err_code_d;

   logic            err_rise;
   logic            last_idx;
   logic [AW-1:0]   idx_nxt;
   logic            to_clr;
   logic            to_en;
   logic            to_expire;

   assign to_en  = is_timed(state_q);
   assign to_clr = !to_en || rx_load;

   uart_frame_timer #(
      .TO_W    (TO_W),
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clkx16 (clkx16),
      .reset  (reset),
      .clr    (to_clr),
      .en     (to_en),
      .expire (to_expire)
   );

   assign err_rise = rx_error && !rx_err_q;
   assign last_idx = (LW'(idx_q) == (len_q - LW'(1)));
   assign idx_nxt  = idx_q + AW'(1);

   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      len_d       = len_q;
      idx_d       = idx_q;
      sum_d       = sum_q;
      pbuf_d      = pbuf_q;
      rst_cnt_d   = rst_cnt_q;
      rx_err_d    = rx_error;
      wr_en_d     = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      wr_cmd_d    = wr_cmd_q;
      frame_ok_d  = 1'b0;
      frame_err_d = 1'b0;
      err_code_d  = err_code_q;

      // A fresh receiver error outranks everything, including writes in flight.
      if (err_rise) begin
         frame_err_d = 1'b1;
         err_code_d  = ERR_UART;
         rst_cnt_d   = 1'b0;
         state_d     = ST_RXRST;
      end else if (to_expire) begin
         frame_err_d = 1'b1;
         err_code_d  = ERR_TO;
         state_d     = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (rx_load && (rx_data == SOF)) begin
                  state_d = ST_CMD;
               end
            end
            ST_CMD: begin
               if (rx_load) begin
                  cmd_d   = rx_data;
                  sum_d   = rx_data;
                  state_d = ST_LEN;
               end
            end
            ST_LEN: begin
               if (rx_load) begin
                  sum_d = sum_q + rx_data;
                  if (rx_data > MAX_LEN_B) begin
                     frame_err_d = 1'b1;
                     err_code_d  = ERR_LEN;
                     state_d     = ST_IDLE;
                  end else if (rx_data == 8'd0) begin
                     len_d   = '0;
                     state_d = ST_CSUM;
                  end else begin
                     len_d   = rx_data[LW-1:0];
                     idx_d   = '0;
                     state_d = ST_PAYLOAD;
                  end
               end
            end
            ST_PAYLOAD: begin
               if (rx_load) begin
                  pbuf_d[idx_q] = rx_data;
                  sum_d         = sum_q + rx_data;
                  if (last_idx) begin
                     state_d = ST_CSUM;
                  end else begin
                     idx_d = idx_nxt;
                  end
               end
            end
            ST_CSUM: begin
               if (rx_load) begin
                  if (rx_data != sum_q) begin
                     frame_err_d = 1'b1;
                     err_code_d  = ERR_CSUM;
                     state_d     = ST_IDLE;
                  end else if (len_q == '0) begin
                     frame_ok_d = 1'b1;
                     state_d    = ST_IDLE;
                  end else begin
                     // First write leaves on the very next edge to meet the latency target.
                     idx_d     = '0;
                     wr_en_d   = 1'b1;
                     wr_addr_d = '0;
                     wr_data_d = pbuf_q[0];
                     wr_cmd_d  = cmd_q;
                     state_d   = ST_COMMIT;
                  end
               end
            end
            ST_COMMIT: begin
               if (last_idx) begin
                  frame_ok_d = 1'b1;
                  state_d    = ST_IDLE;
               end else begin
                  idx_d     = idx_nxt;
                  wr_en_d   = 1'b1;
                  wr_addr_d = idx_nxt;
                  wr_data_d = pbuf_q[idx_nxt];
               end
            end
            ST_RXRST: begin
               if (rst_cnt_q) begin
                  state_d = ST_IDLE;
               end else begin
                  rst_cnt_d = 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clkx16) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cmd_q       <= '0;
         len_q       <= '0;
         idx_q       <= '0;
         sum_q       <= '0;
         rst_cnt_q   <= 1'b0;
         rx_err_q    <= 1'b0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         wr_cmd_q    <= '0;
         frame_ok_q  <= 1'b0;
         frame_err_q <= 1'b0;
         err_code_q  <= '0;
         for (int i = 0; i < MAX_LEN; i++) begin
            pbuf_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         len_q       <= len_d;
         idx_q       <= idx_d;
         sum_q       <= sum_d;
         rst_cnt_q   <= rst_cnt_d;
         rx_err_q    <= rx_err_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         wr_cmd_q    <= wr_cmd_d;
         frame_ok_q  <= frame_ok_d;
         frame_err_q <= frame_err_d;
         err_code_q  <= err_code_d;
         pbuf_q      <= pbuf_d;
      end
   end

   assign uart_rst  = (state_q == ST_RXRST);
   assign busy      = (state_q != ST_IDLE);
   assign wr_en     = wr_en_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign wr_cmd    = wr_cmd_q;
   assign frame_ok  = frame_ok_q;
   assign frame_err = frame_err_q;
   assign err_code  = err_code_q;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Bench for uart_frame_ctrl: directed frames plus random frames, scored against
// a frame-level model of expected writes, completions and aborts with cycle stamps.
module tb_uart_frame_ctrl;

   localparam int MAX_LEN = 8;
   localparam int AW      = 3;
   localparam int TIMEOUT = 640;
   localparam logic [7:0] SOF_B = 8'hA5;

   logic          clkx16 = 1'b0;
   logic          reset  = 1'b1;
   logic [7:0]    rx_data = '0;
   logic          rx_load = 1'b0;
   logic          rx_error = 1'b0;
   logic          uart_rst;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;
   logic [7:0]    wr_cmd;
   logic          frame_ok;
   logic          frame_err;
   logic [1:0]    err_code;
   logic          busy;

   uart_frame_ctrl #(
      .MAX_LEN (MAX_LEN),
      .AW      (AW),
      .TO_W    (16),
      .TIMEOUT (TIMEOUT),
      .SOF     (SOF_B)
   ) dut (
      .clkx16    (clkx16),
      .reset     (reset),
      .rx_data   (rx_data),
      .rx_load   (rx_load),
      .rx_error  (rx_error),
      .uart_rst  (uart_rst),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_cmd    (wr_cmd),
      .frame_ok  (frame_ok),
      .frame_err (frame_err),
      .err_code  (err_code),
      .busy      (busy)
   );

   always #5 clkx16 = ~clkx16;

   int cyc = 0;
   always @(posedge clkx16) cyc <= cyc + 1;

   typedef struct {
      int cyc;
      int a;
      int b;
      int c;
   } ev_t;

   ev_t wr_act[$], wr_exp[$], ok_act[$], ok_exp[$], err_act[$], err_exp[$];

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] pl [16];
   int exp_code = 0;
   int exp_cmd  = 0;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   always @(negedge clkx16) begin
      if (wr_en) wr_act.push_back(ev_t'{cyc, int'(wr_addr), int'(wr_data), int'(wr_cmd)});
      if (frame_ok) ok_act.push_back(ev_t'{cyc, 0, 0, 0});
      if (frame_err) err_act.push_back(ev_t'{cyc, int'(err_code), 0, 0});
      if (frame_ok || frame_err) check_eq("ok_err_exclusive", int'(frame_ok & frame_err), 0);
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clkx16);
         #1;
      end
   endtask

   // Entered and left at #1 after a rising edge; scyc is the cycle stamp of the strobe edge.
   task automatic send_byte(input logic [7:0] b, input int gap, output int scyc);
      rx_data = b;
      rx_load = 1'b1;
      tick(1);
      scyc    = cyc;
      rx_load = 1'b0;
      rx_data = 8'($urandom);
      tick(gap);
   endtask

   task automatic clear_events();
      wr_act.delete();
      wr_exp.delete();
      ok_act.delete();
      ok_exp.delete();
      err_act.delete();
      err_exp.delete();
   endtask

   task automatic compare_events(input string tag);
      check_eq({tag, "_n_wr"}, wr_act.size(), wr_exp.size());
      for (int i = 0; i < wr_act.size() && i < wr_exp.size(); i++) begin
         check_eq({tag, "_wr_cyc"},  wr_act[i].cyc, wr_exp[i].cyc);
         check_eq({tag, "_wr_addr"}, wr_act[i].a,   wr_exp[i].a);
         check_eq({tag, "_wr_data"}, wr_act[i].b,   wr_exp[i].b);
         check_eq({tag, "_wr_cmd"},  wr_act[i].c,   wr_exp[i].c);
      end
      check_eq({tag, "_n_ok"}, ok_act.size(), ok_exp.size());
      for (int i = 0; i < ok_act.size() && i < ok_exp.size(); i++) begin
         check_eq({tag, "_ok_cyc"}, ok_act[i].cyc, ok_exp[i].cyc);
      end
      check_eq({tag, "_n_err"}, err_act.size(), err_exp.size());
      for (int i = 0; i < err_act.size() && i < err_exp.size(); i++) begin
         check_eq({tag, "_err_cyc"},  err_act[i].cyc, err_exp[i].cyc);
         check_eq({tag, "_err_code"}, err_act[i].a,   err_exp[i].a);
      end
      check_eq({tag, "_err_code_hold"}, int'(err_code), exp_code);
      check_eq({tag, "_wr_cmd_hold"},   int'(wr_cmd),   exp_cmd);
   endtask

   // Frame-level model: SOF, cmd, len, payload pl[0..len-1], checksum offset by delta.
   task automatic run_frame(input logic [7:0] cmd, input int len, input logic [7:0] delta,
                            input int max_gap, output int s);
      logic [7:0] sum;
      send_byte(SOF_B, $urandom_range(0, max_gap), s);
      send_byte(cmd, $urandom_range(0, max_gap), s);
      if (len > MAX_LEN) begin
         send_byte(8'(len), 0, s);
         err_exp.push_back(ev_t'{s, 1, 0, 0});
         exp_code = 1;
      end else begin
         send_byte(8'(len), $urandom_range(0, max_gap), s);
         sum = cmd + 8'(len);
         for (int i = 0; i < len; i++) begin
            send_byte(pl[i], $urandom_range(0, max_gap), s);
            sum = sum + pl[i];
         end
         send_byte(sum + delta, 0, s);
         if (delta != 8'd0) begin
            err_exp.push_back(ev_t'{s, 0, 0, 0});
            exp_code = 0;
         end else begin
            for (int i = 0; i < len; i++) begin
               wr_exp.push_back(ev_t'{s + i, i, int'(pl[i]), int'(cmd)});
            end
            ok_exp.push_back(ev_t'{s + len, 0, 0, 0});
            if (len > 0) exp_cmd = int'(cmd);
         end
      end
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_wr_en"},     int'(wr_en),     0);
      check_eq({tag, "_wr_addr"},   int'(wr_addr),   0);
      check_eq({tag, "_wr_data"},   int'(wr_data),   0);
      check_eq({tag, "_wr_cmd"},    int'(wr_cmd),    0);
      check_eq({tag, "_frame_ok"},  int'(frame_ok),  0);
      check_eq({tag, "_frame_err"}, int'(frame_err), 0);
      check_eq({tag, "_err_code"},  int'(err_code),  0);
      check_eq({tag, "_uart_rst"},  int'(uart_rst),  0);
      check_eq({tag, "_busy"},      int'(busy),      0);
   endtask

   initial begin
      int s;
      logic [7:0] junk;
      int len;
      logic [7:0] delta;

      reset = 1'b1;
      tick(3);
      @(negedge clkx16);
      check_all_zero("reset");
      @(posedge clkx16);
      #1;
      reset = 1'b0;
      tick(2);

      // Good two-byte frame; checksum 01+02+10+20 = 33.
      clear_events();
      pl[0] = 8'h10;
      pl[1] = 8'h20;
      run_frame(8'h01, 2, 8'h00, 3, s);
      tick(20);
      compare_events("good");

      // Same frame with checksum 34.
      clear_events();
      run_frame(8'h01, 2, 8'h01, 3, s);
      tick(20);
      compare_events("bad_csum");

      // Oversized length, then a stray byte that must be ignored in IDLE.
      clear_events();
      run_frame(8'h01, 9, 8'h00, 3, s);
      send_byte(8'h10, 5, s);
      tick(10);
      compare_events("len");
      check_eq("len_busy", int'(busy), 0);

      // Inter-byte timeout after the command byte.
      clear_events();
      send_byte(SOF_B, 2, s);
      send_byte(8'h07, 0, s);
      err_exp.push_back(ev_t'{s + TIMEOUT, 2, 0, 0});
      exp_code = 2;
      tick(TIMEOUT + 20);
      compare_events("timeout");
      check_eq("timeout_busy", int'(busy), 0);

      // Receiver error rising together with a payload strobe.
      clear_events();
      send_byte(SOF_B, 2, s);
      send_byte(8'h01, 2, s);
      send_byte(8'h03, 2, s);
      send_byte(8'h10, 2, s);
      rx_error = 1'b1;
      send_byte(8'h20, 0, s);
      err_exp.push_back(ev_t'{s, 3, 0, 0});
      exp_code = 3;
      @(negedge clkx16);
      check_eq("uerr_rst_c0", int'(uart_rst), 1);
      check_eq("uerr_busy_c0", int'(busy), 1);
      @(negedge clkx16);
      check_eq("uerr_rst_c1", int'(uart_rst), 1);
      @(negedge clkx16);
      check_eq("uerr_rst_c2", int'(uart_rst), 0);
      check_eq("uerr_busy_c2", int'(busy), 0);
      @(posedge clkx16);
      #1;
      run_frame(8'h00, 0, 8'h00, 3, s);
      tick(20);
      compare_events("uart_err");
      rx_error = 1'b0;
      tick(3);

      // Reset in the middle of committing a four-byte frame.
      clear_events();
      for (int i = 0; i < 4; i++) pl[i] = 8'($urandom);
      run_frame(8'($urandom), 4, 8'h00, 3, s);
      tick(1);
      reset = 1'b1;
      tick(1);
      @(negedge clkx16);
      check_all_zero("mid_reset");
      @(posedge clkx16);
      #1;
      reset = 1'b0;
      while (wr_exp.size() > 2) void'(wr_exp.pop_back());
      ok_exp.delete();
      exp_code = 0;
      exp_cmd  = 0;
      tick(20);
      compare_events("mid_reset");

      // Random frames with line noise before SOF.
      for (int n = 0; n < 40; n++) begin
         clear_events();
         repeat ($urandom_range(0, 2)) begin
            junk = 8'($urandom);
            if (junk == SOF_B) junk = 8'h5A;
            send_byte(junk, $urandom_range(0, 6), s);
         end
         len = $urandom_range(0, 10);
         for (int i = 0; i < 16; i++) pl[i] = 8'($urandom);
         delta = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
         run_frame(8'($urandom), len, delta, 12, s);
         tick(20);
         compare_events("rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
